mul_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the shared 64x64 signed Booth multiplier (`multiplier` module). It accepts multiply requests from two independent requesters and latches the winner's operands. It drives the multiplier's `op_start`/`op_clear` handshake, captures the 128-bit product, and returns it to the owning port with a one-cycle valid pulse. A watchdog aborts any operation whose `op_done` never arrives.

---
 rtl/mul_arbiter.sv | 148 ++++++++++++++
 tb/tb_mul_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared 64x64 signed multiplier.
// Latches the winner's operands, runs the start/done/clear handshake and returns the product with a watchdog abort.
module mul_arbiter #(
  parameter int unsigned TIMEOUT = 127
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [63:0]  a0,
  input  logic [63:0]  b0,
  input  logic [63:0]  a1,
  input  logic [63:0]  b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         resp_valid0,
  output logic         resp_valid1,
  output logic [127:0] resp_data,
  output logic         resp_err,
  output logic         busy,
  output logic [63:0]  m_multiplier,
  output logic [63:0]  m_multiplicand,
  output logic         m_op_start,
  output logic         m_op_clear,
  input  logic         m_op_done,
  input  logic [127:0] m_result
);

  localparam int unsigned DW  = 64;
  localparam int unsigned PW  = 128;
  localparam int unsigned WDW = 8;

  typedef enum logic [1:0] {IDLE, START, RUN, CLR} state_t;

  state_t         state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_q, last_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [DW-1:0]  opa_d, opb_d;
  logic [PW-1:0]  data_d;
  logic           err_d;
  logic           gnt0_d, gnt1_d, rv0_d, rv1_d, start_d, clear_d, busy_d;
  logic           win_c;

  // Contended requests go to the port that did not win last; otherwise to the sole requester.
  assign win_c = (req0 && req1) ? ~last_q : req1;

  // Next-state and next-output decode; outputs are registered from the next state.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wd_d    = wd_q;
    opa_d   = m_multiplier;
    opb_d   = m_multiplicand;
    data_d  = resp_data;
    err_d   = resp_err;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    start_d = 1'b0;
    clear_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d = win_c;
          last_d  = win_c;
          opa_d   = win_c ? a1 : a0;
          opb_d   = win_c ? b1 : b0;
          gnt0_d  = ~win_c;
          gnt1_d  = win_c;
          start_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        wd_d    = '0;
        state_d = RUN;
      end
      RUN: begin
        // Completion takes priority over a simultaneous watchdog expiry.
        if (m_op_done) begin
          data_d  = m_result;
          err_d   = 1'b0;
          rv0_d   = ~owner_q;
          rv1_d   = owner_q;
          clear_d = 1'b1;
          state_d = CLR;
        end else if (wd_q == WDW'(TIMEOUT)) begin
          data_d  = '0;
          err_d   = 1'b1;
          rv0_d   = ~owner_q;
          rv1_d   = owner_q;
          clear_d = 1'b1;
          state_d = CLR;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      CLR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      last_q         <= 1'b1;
      wd_q           <= '0;
      m_multiplier   <= '0;
      m_multiplicand <= '0;
      resp_data      <= '0;
      resp_err       <= 1'b0;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      resp_valid0    <= 1'b0;
      resp_valid1    <= 1'b0;
      m_op_start     <= 1'b0;
      m_op_clear     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_q         <= last_d;
      wd_q           <= wd_d;
      m_multiplier   <= opa_d;
      m_multiplicand <= opb_d;
      resp_data      <= data_d;
      resp_err       <= err_d;
      gnt0           <= gnt0_d;
      gnt1           <= gnt1_d;
      resp_valid0    <= rv0_d;
      resp_valid1    <= rv1_d;
      m_op_start     <= start_d;
      m_op_clear     <= clear_d;
      busy           <= busy_d;
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural 64-cycle multiplier stub.
module tb_mul_arbiter;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [63:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, resp_valid0, resp_valid1, resp_err, busy;
  logic [127:0] resp_data;
  logic [63:0]  m_multiplier, m_multiplicand;
  logic         m_op_start, m_op_clear, m_op_done;
  logic [127:0] m_result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic stuck = 1'b0;

  mul_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
    .m_multiplier(m_multiplier), .m_multiplicand(m_multiplicand),
    .m_op_start(m_op_start), .m_op_clear(m_op_clear),
    .m_op_done(m_op_done), .m_result(m_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stub: done 64 cycles after entering MULTIPLYING, product from operands at that point.
  logic         mbusy, mdone;
  logic [6:0]   mcnt;
  logic [127:0] mprod, sa, sb;
  assign sa = {{64{m_multiplier[63]}}, m_multiplier};
  assign sb = {{64{m_multiplicand[63]}}, m_multiplicand};
  assign m_op_done = mdone & ~stuck;
  assign m_result  = mprod;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mbusy <= 1'b0; mdone <= 1'b0; mcnt <= '0; mprod <= '0;
    end else if (m_op_clear) begin
      mbusy <= 1'b0; mdone <= 1'b0;
    end else if (m_op_start && !mbusy && !mdone) begin
      mbusy <= 1'b1; mcnt <= '0;
    end else if (mbusy) begin
      if (mcnt == 7'd63) begin
        mbusy <= 1'b0; mdone <= 1'b1; mprod <= sa * sb;
      end else begin
        mcnt <= mcnt + 7'd1;
      end
    end
  end

  // Monitors: operand stability while busy, exclusivity, pulse counters.
  int viol = 0, both_hi = 0, clr_cnt = 0, rv_cnt = 0;
  logic prev_busy = 1'b0;
  logic [63:0] held_a, held_b;
  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      held_a = m_multiplier; held_b = m_multiplicand;
    end else if (busy && (m_multiplier !== held_a || m_multiplicand !== held_b)) begin
      viol++;
    end
    prev_busy = busy;
    if ((gnt0 && gnt1) || (resp_valid0 && resp_valid1)) both_hi++;
    if (m_op_clear) clr_cnt++;
    if (resp_valid0 || resp_valid1) rv_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return gnt0;
      1: return gnt1;
      2: return resp_valid0;
      3: return resp_valid1;
      4: return m_op_clear;
      5: return gnt0 | gnt1;
      default: return resp_valid0 | resp_valid1;
    endcase
  endfunction

  task automatic wait_sig(input int sel, output int at);
    at = -1;
    for (int i = 0; i < 400 && at < 0; i++) begin
      @(negedge clk);
      if (sig(sel)) at = cyc;
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, 128'({gnt0, gnt1, resp_valid0, resp_valid1, resp_err, busy, m_op_start, m_op_clear}), '0);
    chk({tag, "_data"}, resp_data, '0);
    chk({tag, "_mplier"}, 128'(m_multiplier), '0);
    chk({tag, "_mcand"}, 128'(m_multiplicand), '0);
  endtask

  // One transaction from IDLE: request, grant latency, response latency and payload.
  task automatic do_txn(input int p, input logic [63:0] a, input logic [63:0] b,
                        input logic [127:0] exp, input logic exp_err, input int lat);
    int t0, g, r;
    if (p == 0) begin a0 = a; b0 = b; req0 = 1'b1; end
    else        begin a1 = a; b1 = b; req1 = 1'b1; end
    t0 = cyc;
    wait_sig(p, g);
    chk("gnt_lat", 128'(g), 128'(t0 + 1));
    chk("start", 128'(m_op_start), 128'(1));
    chk("busy_hi", 128'(busy), 128'(1));
    req0 = 1'b0; req1 = 1'b0;
    wait_sig(2 + p, r);
    chk("resp_lat", 128'(r), 128'(g + lat));
    chk("resp_data", resp_data, exp);
    chk("resp_err", 128'(resp_err), 128'(exp_err));
    chk("resp_other", 128'(p == 0 ? resp_valid1 : resp_valid0), 128'(0));
    chk("clear", 128'(m_op_clear), 128'(1));
    @(negedge clk);
    chk("busy_lo", 128'(busy), 128'(0));
  endtask

  initial begin
    int g, r, c0, rv0_snap;

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Single-port products
    do_txn(0, 64'd3, 64'd5, 128'd15, 1'b0, 66);
    do_txn(1, 64'(-7), 64'd9, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFC1, 1'b0, 66);
    do_txn(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 66);

    // Both requests high from reset: alternate 0,1,0,1
    @(negedge clk);
    reset_n = 1'b0;
    a0 = 64'd6; b0 = 64'd7; a1 = 64'(-3); b1 = 64'(-11);
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_sig(5, g);
      chk("alt_gnt0", 128'(gnt0), 128'(i % 2 == 0));
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
      wait_sig(6, r);
      chk("alt_rv_lat", 128'(r), 128'(g + 66));
      chk("alt_rv0", 128'(resp_valid0), 128'(i % 2 == 0));
      chk("alt_data", resp_data, (i % 2 == 0) ? 128'd42 : 128'd33);
    end
    @(negedge clk);

    // Operands change while busy; product must follow the latched values
    a0 = 64'd100; b0 = 64'(-2); req0 = 1'b1;
    wait_sig(0, g);
    req0 = 1'b0;
    @(negedge clk);
    a0 = 64'h1234; b0 = 64'h5678; a1 = 64'h9ABC; b1 = 64'hDEF0;
    wait_sig(2, r);
    chk("hold_data", resp_data, {{120{1'b1}}, 8'h38});
    chk("hold_stable", 128'(viol), 128'(0));
    @(negedge clk);

    // Watchdog abort with op_done stuck low, then normal recovery
    stuck = 1'b1;
    c0 = clr_cnt;
    do_txn(0, 64'd3, 64'd5, 128'd0, 1'b1, 129);
    repeat (3) @(negedge clk);
    chk("abort_one_clear", 128'(clr_cnt - c0), 128'(1));
    stuck = 1'b0;
    do_txn(0, 64'd2, 64'd21, 128'd42, 1'b0, 66);

    // Reset pulsed mid-operation
    a0 = 64'd9; b0 = 64'd9; req0 = 1'b1;
    wait_sig(0, g);
    req0 = 1'b0;
    repeat (30) @(negedge clk);
    rv0_snap = rv_cnt;
    reset_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("midrst_no_resp", 128'(rv_cnt - rv0_snap), 128'(0));
    do_txn(0, 64'd4, 64'd4, 128'd16, 1'b0, 66);

    chk("exclusive", 128'(both_hi), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
